// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//  Shared definitions for the streaming UART transmitter:
//  parity mode encodings, transmitter FSM state encoding and the
//  helpers used to reject illegal parameter sets at elaboration.
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int clk_div, input int data_bits,
                                   input int parity, input int stop_bits,
                                   input int fifo_depth);
    return (clk_div >= 2) &&
           (data_bits >= 5) && (data_bits <= 8) &&
           ((parity == PARITY_NONE) || (parity == PARITY_ODD) ||
            (parity == PARITY_EVEN)) &&
           ((stop_bits == 1) || (stop_bits == 2)) &&
           (fifo_depth >= 2) && is_pow2(fifo_depth);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//  Single-clock FIFO with first-word fall-through read data and a fill level.
//  Pointers carry one extra MSB so full and empty are distinguishable
//  without a separate counter.
// Ports
//  clk, rst_n   clock, async active-low reset (flushes pointers)
//  wr_en        write request; ignored while full
//  wr_data      word to write
//  rd_en        read (pop) request; ignored while empty
//  rd_data      head of the FIFO, valid whenever empty = 0
//  full, empty  status flags
//  level        number of words held, 0..DEPTH
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;

  // A write while full is refused even if a read happens on the same edge.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// ----------------------------------------------------------------------------
// uart_tx_stream
//  UART transmitter fed by a valid/ready stream through a TX FIFO.
//  Frames are sent back-to-back with no idle gap while words are queued.
//  Each bit lasts CLK_DIV clocks; the baud counter restarts every frame.
// Ports
//  clk         system clock
//  rst_n       async active-low reset; aborts any frame and flushes the FIFO
//  s_data      word to transmit
//  s_valid     s_data valid
//  s_ready     FIFO not full
//  tx          serial line, idle high, registered
//  busy        frame in progress or words queued
//  tx_done     one-cycle pulse in the last cycle of the last stop bit on tx
//  fifo_level  words currently queued
//
//  state     | meaning
//  ST_IDLE   | line idle, waiting for a queued word
//  ST_START  | start bit (low)
//  ST_DATA   | data bits, LSB first
//  ST_PARITY | parity bit over the data bits
//  ST_STOP   | stop bit(s) (high); pops the next word on the final cycle
// ----------------------------------------------------------------------------
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 60,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  if (!params_ok(CLK_DIV, DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH)) begin : g_bad_params
    $error("uart_tx_stream: illegal parameter set");
  end

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  tx_state_t             state;
  logic [CNT_W-1:0]      baud_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par_bit;
  logic                  line;
  logic                  bit_end;
  logic                  frame_end;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_BITS-1:0]  head;

  // fifo_full is exactly fifo_level == FIFO_DEPTH
  assign s_ready = !fifo_full;
  assign push    = s_valid && s_ready;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (s_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign bit_end   = (baud_cnt == CNT_LAST);
  assign frame_end = (state == ST_STOP) && bit_end && (bit_idx == STOP_LAST);

  // Pop from idle, or on the last stop cycle so the next start bit follows
  // without a gap.
  assign pop  = !fifo_empty && ((state == ST_IDLE) || frame_end);
  assign busy = (state != ST_IDLE) || (fifo_level != '0);

  always_comb begin
    line = 1'b1;
    case (state)
      ST_START:  line = 1'b0;
      ST_DATA:   line = shreg[0];
      ST_PARITY: line = par_bit;
      default:   line = 1'b1;
    endcase
  end

  // tx and tx_done are registered copies of the state-derived values, so the
  // line trails the FSM by one clock (pop edge -> tx low one clock later).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx      <= line;
      tx_done <= frame_end;

      if (pop) begin
        shreg   <= head;
        par_bit <= (PARITY == PARITY_ODD) ? ~^head : ^head;
      end

      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (pop) state <= ST_START;
        end
        default: begin
          if (!bit_end) begin
            baud_cnt <= baud_cnt + 1'b1;
          end else begin
            baud_cnt <= '0;
            case (state)
              ST_START: begin
                state   <= ST_DATA;
                bit_idx <= '0;
              end
              ST_DATA: begin
                shreg <= shreg >> 1;
                if (bit_idx == DATA_LAST) begin
                  bit_idx <= '0;
                  state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end else begin
                  bit_idx <= bit_idx + 1'b1;
                end
              end
              ST_PARITY: begin
                state   <= ST_STOP;
                bit_idx <= '0;
              end
              ST_STOP: begin
                if (bit_idx == STOP_LAST) begin
                  bit_idx <= '0;
                  state   <= pop ? ST_START : ST_IDLE;
                end else begin
                  bit_idx <= bit_idx + 1'b1;
                end
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_stream
//  Directed bench for uart_tx_stream with CLK_DIV=4:
//   u_a  8N1, depth 16   (reset, single word, burst, mid-frame reset)
//   u_b  8N1, depth 4    (full FIFO with s_valid held)
//   u_c  7O2, u_d 7E2    (frame format, driven in parallel)
//  Line vectors are stored with bit 0 = first bit on the line (start bit).
// ----------------------------------------------------------------------------
module tb_uart_tx_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] s_data_a = '0;
  logic       s_valid_a = 1'b0;
  logic       s_ready_a, tx_a, busy_a, tx_done_a;
  logic [4:0] level_a;

  logic [7:0] s_data_b = '0;
  logic       s_valid_b = 1'b0;
  logic       s_ready_b, tx_b, busy_b, tx_done_b;
  logic [2:0] level_b;

  logic [6:0] s_data_cd = '0;
  logic       s_valid_cd = 1'b0;
  logic       s_ready_c, tx_c, busy_c, tx_done_c;
  logic       s_ready_d, tx_d, busy_d, tx_done_d;
  logic [4:0] level_c, level_d;

  int checks = 0;
  int errors = 0;

  uart_tx_stream #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
    .tx(tx_a), .busy(busy_a), .tx_done(tx_done_a), .fifo_level(level_a));

  uart_tx_stream #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .tx(tx_b), .busy(busy_b), .tx_done(tx_done_b), .fifo_level(level_b));

  uart_tx_stream #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) u_c (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_cd), .s_valid(s_valid_cd), .s_ready(s_ready_c),
    .tx(tx_c), .busy(busy_c), .tx_done(tx_done_c), .fifo_level(level_c));

  uart_tx_stream #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u_d (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_cd), .s_valid(s_valid_cd), .s_ready(s_ready_d),
    .tx(tx_d), .busy(busy_d), .tx_done(tx_done_d), .fifo_level(level_d));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input int sel);
    case (sel)
      0:       return tx_a;
      1:       return tx_b;
      2:       return tx_c;
      default: return tx_d;
    endcase
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return tx_done_a;
      1:       return tx_done_b;
      2:       return tx_done_c;
      default: return tx_done_d;
    endcase
  endfunction

  // Waits (bounded) for the start bit, then samples the first and last clock
  // of every bit and records where tx_done fires within the frame.
  task automatic frame(input string tag, input int sel, input int nbits,
                       input logic [15:0] exp, output int waits);
    logic [15:0] b0, b3;
    int done_k, done_n;
    b0 = '0; b3 = '0; done_k = -1; done_n = 0; waits = 0;
    while (tx_of(sel) !== 1'b0 && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    for (int k = 0; k < nbits * 4; k++) begin
      if (k > 0) @(negedge clk);
      if (k % 4 == 0) b0[k/4] = tx_of(sel);
      if (k % 4 == 3) b3[k/4] = tx_of(sel);
      if (done_of(sel) === 1'b1) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
    end
    check({tag, "_bits_first_clk"}, 32'(b0), 32'(exp));
    check({tag, "_bits_last_clk"},  32'(b3), 32'(exp));
    check({tag, "_done_pos"},       32'(done_k), 32'(nbits * 4 - 1));
    check({tag, "_done_count"},     32'(done_n), 32'd1);
  endtask

  task automatic push_a(input logic [7:0] d);
    s_data_a  = d;
    s_valid_a = 1'b1;
    @(negedge clk);
    s_valid_a = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, wc, wd, lows, pushed, n, seen_full;
    logic acc;
    logic [7:0] wl [6];
    wl[0] = 8'h11; wl[1] = 8'h22; wl[2] = 8'h33;
    wl[3] = 8'h44; wl[4] = 8'h5A; wl[5] = 8'hC3;

    // 1: reset idle
    repeat (3) @(negedge clk);
    check("rst_tx",      32'(tx_a), 32'd1);
    check("rst_ready",   32'(s_ready_a), 32'd1);
    check("rst_busy",    32'(busy_a), 32'd0);
    check("rst_level",   32'(level_a), 32'd0);
    check("rst_done",    32'(tx_done_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_tx",     32'(tx_a), 32'd1);
    check("idle_busy",   32'(busy_a), 32'd0);
    check("idle_ready_b", 32'(s_ready_b), 32'd1);

    // 2: single 8N1 word, latency and line shape
    push_a(8'hA5);
    check("push_level",  32'(level_a), 32'd1);
    check("push_busy",   32'(busy_a), 32'd1);
    @(negedge clk);
    check("lat_1clk_tx", 32'(tx_a), 32'd1);
    check("pop_level",   32'(level_a), 32'd0);
    @(negedge clk);
    check("lat_2clk_tx", 32'(tx_a), 32'd0);
    frame("a5", 0, 10, 16'h34A, w);
    check("a5_wait", 32'(w), 32'd0);
    @(negedge clk);
    check("a5_idle_busy", 32'(busy_a), 32'd0);
    check("a5_idle_tx",   32'(tx_a), 32'd1);

    // 3: burst of three, gap-free, tx_done 40 clk apart
    s_data_a = 8'h00; s_valid_a = 1'b1;
    @(negedge clk);
    s_data_a = 8'hFF;
    @(negedge clk);
    s_data_a = 8'h55;
    @(negedge clk);
    s_valid_a = 1'b0;
    check("burst_level", 32'(level_a), 32'd2);
    check("burst_busy",  32'(busy_a), 32'd1);
    frame("b00", 0, 10, 16'h200, w);
    check("b00_wait", 32'(w), 32'd0);
    frame("bff", 0, 10, 16'h3FE, w);
    check("bff_gap", 32'(w), 32'd1);
    frame("b55", 0, 10, 16'h2AA, w);
    check("b55_gap", 32'(w), 32'd1);
    @(negedge clk);
    check("burst_end_busy",  32'(busy_a), 32'd0);
    check("burst_end_level", 32'(level_a), 32'd0);

    // 4: depth-4 FIFO, six words with s_valid held
    fork
      begin
        pushed = 0; n = 0; seen_full = 0;
        s_data_b = wl[0]; s_valid_b = 1'b1;
        while (pushed < 6 && n < 2000) begin
          if (level_b == 3'd4 && seen_full == 0) begin
            seen_full = 1;
            check("full_ready_low", 32'(s_ready_b), 32'd0);
          end
          acc = s_ready_b;
          @(negedge clk);
          n++;
          if (acc) begin
            pushed++;
            if (pushed < 6) s_data_b = wl[pushed];
          end
        end
        s_valid_b = 1'b0;
        check("full_all_pushed", 32'(pushed), 32'd6);
        check("full_seen",       32'(seen_full), 32'd1);
      end
      begin
        for (int i = 0; i < 6; i++) begin
          frame($sformatf("full%0d", i), 1, 10, {7'b0, 1'b1, wl[i], 1'b0}, w);
          if (i == 0) check("full0_started", 32'(w < 200), 32'd1);
          else        check($sformatf("full%0d_gap", i), 32'(w), 32'd1);
        end
      end
    join
    repeat (2) @(negedge clk);
    check("full_end_level", 32'(level_b), 32'd0);
    check("full_end_busy",  32'(busy_b), 32'd0);

    // 5: 7O2 and 7E2, word 7'h03
    s_data_cd = 7'h03; s_valid_cd = 1'b1;
    @(negedge clk);
    s_valid_cd = 1'b0;
    fork
      frame("o2", 2, 11, 16'h706, wc);
      frame("e2", 3, 11, 16'h606, wd);
    join
    check("o2_wait", 32'(wc), 32'd2);
    check("e2_wait", 32'(wd), 32'd2);
    @(negedge clk);
    check("fmt_idle_busy", 32'(busy_c), 32'd0);

    // 6: reset during data bit 3 of the second queued word
    s_data_a = 8'hFF; s_valid_a = 1'b1;
    @(negedge clk);
    s_data_a = 8'h81;
    @(negedge clk);
    s_data_a = 8'h42;
    @(negedge clk);
    s_valid_a = 1'b0;
    frame("r0", 0, 10, 16'h3FE, w);
    check("r0_wait", 32'(w), 32'd0);
    @(negedge clk);
    check("r1_start", 32'(tx_a), 32'd0);
    repeat (17) @(negedge clk);
    check("r1_bit3",  32'(tx_a), 32'd0);
    check("r1_level", 32'(level_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tx",    32'(tx_a), 32'd1);
    check("rst_async_level", 32'(level_a), 32'd0);
    check("rst_async_busy",  32'(busy_a), 32'd0);
    check("rst_async_ready", 32'(s_ready_a), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1) lows++;
    end
    check("post_rst_no_frame", 32'(lows), 32'd0);
    check("post_rst_busy",     32'(busy_a), 32'd0);
    push_a(8'h5A);
    frame("post", 0, 10, 16'h2B4, w);
    check("post_wait", 32'(w), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
